// File: rtl/p4_pkg.sv
// Shared constants and tree-shape helpers for the sparse-tree adder.
package p4_pkg;

  localparam int P4_DWIDTH     = 32;
  localparam int P4_CARRY_STEP = 4;

  typedef enum logic [1:0] {
    CELL_NONE,
    CELL_G,
    CELL_PG
  } cell_e;

  function automatic int tree_levels(int w);
    return $clog2(w);
  endfunction

  // Levels below ls combine bits inside a carry group (column = bit);
  // higher levels combine whole groups (column = group index).
  function automatic cell_e cell_at(int lvl, int col, int ls);
    int sl;
    if (lvl < ls)
      return ((col + 1) % (2 << lvl) == 0) ? CELL_PG : CELL_NONE;
    sl = lvl - ls;
    if (((col >> sl) & 1) == 0)
      return CELL_NONE;
    return (col < (2 << sl)) ? CELL_G : CELL_PG;
  endfunction

endpackage

// File: rtl/p4_carry_gen.sv
// Sparse prefix tree: Brent-Kung inside each carry group,
// Sklansky fan-out across groups. c_o[k] is the carry into group k+1.
module p4_carry_gen
  import p4_pkg::*;
#(
  parameter int DWIDTH     = P4_DWIDTH,
  parameter int CARRY_STEP = P4_CARRY_STEP
) (
  input  logic [DWIDTH-1:0]            a_i,
  input  logic [DWIDTH-1:0]            b_i,
  input  logic                         cin_i,
  output logic [DWIDTH/CARRY_STEP-1:0] c_o
);

  localparam int LT = tree_levels(DWIDTH);
  localparam int LS = $clog2(CARRY_STEP);
  localparam int LG = LT - LS;
  localparam int NG = DWIDTH / CARRY_STEP;

  logic [DWIDTH-1:0] ug [0:LS];
  logic [DWIDTH-1:0] up [0:LS];
  logic [NG-1:0]     sg [0:LG];
  logic [NG-1:0]     sp [0:LG];
  logic              unused_tree;

  always_comb begin
    ug[0] = a_i & b_i;
    up[0] = a_i ^ b_i;
    ug[0][0] = (a_i[0] & b_i[0]) | (up[0][0] & cin_i);
    for (int l = 0; l < LS; l++) begin
      ug[l+1] = ug[l];
      up[l+1] = up[l];
      for (int i = 0; i < DWIDTH; i++) begin
        if (cell_at(l, i, LS) == CELL_PG) begin
          ug[l+1][i] = ug[l][i] | (up[l][i] & ug[l][i-(1<<l)]);
          up[l+1][i] = up[l][i] & up[l][i-(1<<l)];
        end
      end
    end
    for (int j = 0; j < NG; j++) begin
      sg[0][j] = ug[LS][j*CARRY_STEP+CARRY_STEP-1];
      sp[0][j] = up[LS][j*CARRY_STEP+CARRY_STEP-1];
    end
    for (int l = 0; l < LG; l++) begin
      sg[l+1] = sg[l];
      sp[l+1] = sp[l];
      for (int j = 0; j < NG; j++) begin
        unique case (cell_at(LS + l, j, LS))
          CELL_G: begin
            sg[l+1][j] = sg[l][j] | (sp[l][j] & sg[l][((j>>l)<<l)-1]);
          end
          CELL_PG: begin
            sg[l+1][j] = sg[l][j] | (sp[l][j] & sg[l][((j>>l)<<l)-1]);
            sp[l+1][j] = sp[l][j] & sp[l][((j>>l)<<l)-1];
          end
          default: ;
        endcase
      end
    end
  end

  assign c_o = sg[LG];

  // Non-group-top nodes and final propagates are structural leftovers.
  assign unused_tree = ^{ug[LS], up[LS], sp[LG]};

endmodule

// File: rtl/p4_adder.sv
// Pentium-4-style sparse-tree adder with carry-select sum blocks
// and a registered copy of the result.
module p4_adder
  import p4_pkg::*;
#(
  parameter int DWIDTH     = P4_DWIDTH,
  parameter int CARRY_STEP = P4_CARRY_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic              CIN,
  output logic [DWIDTH-1:0] S,
  output logic              COUT,
  output logic [DWIDTH-1:0] S_reg,
  output logic              COUT_reg
);

  localparam int NG = DWIDTH / CARRY_STEP;

  logic [NG-1:0] c;
  logic [NG-1:0] sel;

  p4_carry_gen #(
    .DWIDTH    (DWIDTH),
    .CARRY_STEP(CARRY_STEP)
  ) u_carry (
    .a_i  (A),
    .b_i  (B),
    .cin_i(CIN),
    .c_o  (c)
  );

  assign sel = {c[NG-2:0], CIN};

  for (genvar k = 0; k < NG; k++) begin : g_blk
    logic [CARRY_STEP-1:0] ab;
    logic [CARRY_STEP-1:0] bb;
    logic [CARRY_STEP-1:0] s0;
    logic [CARRY_STEP-1:0] s1;

    assign ab = A[k*CARRY_STEP +: CARRY_STEP];
    assign bb = B[k*CARRY_STEP +: CARRY_STEP];
    assign s0 = ab + bb;
    assign s1 = ab + bb + 1'b1;
    assign S[k*CARRY_STEP +: CARRY_STEP] = sel[k] ? s1 : s0;
  end

  assign COUT = c[NG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_reg    <= '0;
      COUT_reg <= 1'b0;
    end else begin
      S_reg    <= S;
      COUT_reg <= COUT;
    end
  end

endmodule

// File: tb/tb_p4_adder.sv
// Directed-vector and random check of p4_adder combinational
// and registered outputs against a 33-bit arithmetic reference.
module tb_p4_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        CIN;
  logic [31:0] S;
  logic        COUT;
  logic [31:0] S_reg;
  logic        COUT_reg;

  int applied;
  int miscompares;

  vec_t tv[$];

  p4_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .CIN     (CIN),
    .S       (S),
    .COUT    (COUT),
    .S_reg   (S_reg),
    .COUT_reg(COUT_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] ref_sum;
    logic [32:0] prev;
    applied     = 0;
    miscompares = 0;

    tv.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0});
    tv.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1});
    tv.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0});
    tv.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0});
    tv.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1});
    tv.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1});
    tv.push_back('{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0});
    tv.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0});
    tv.push_back('{32'h0000_0FFF, 32'h0000_0001, 1'b0, 32'h0000_1000, 1'b0});
    tv.push_back('{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0});
    tv.push_back('{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0});
    tv.push_back('{32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 32'h1000_0000, 1'b0});
    tv.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1});
    tv.push_back('{32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 32'h0000_0000, 1'b1});
    tv.push_back('{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1});
    tv.push_back('{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0});
    tv.push_back('{32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 32'h0000_0000, 1'b1});

    rst_n = 1'b0;
    A     = 32'h0;
    B     = 32'h0;
    CIN   = 1'b0;
    @(posedge clk);
    #1;
    check("reset_regs", {COUT_reg, S_reg}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      A   = tv[i].a;
      B   = tv[i].b;
      CIN = tv[i].cin;
      #1;
      check($sformatf("vec%0d_comb", i), {COUT, S}, {tv[i].cout, tv[i].s});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_reg", i), {COUT_reg, S_reg},
            {tv[i].cout, tv[i].s});
    end

    @(negedge clk);
    A   = 32'd5;
    B   = 32'd7;
    CIN = 1'b0;
    @(posedge clk);
    #1;
    check("rst_seq_pre", {COUT_reg, S_reg}, 33'd12);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_seq_async_clear", {COUT_reg, S_reg}, 33'd0);
    check("rst_seq_comb_kept", {COUT, S}, 33'd12);
    @(negedge clk);
    #1;
    check("rst_seq_hold_low", {COUT_reg, S_reg}, 33'd0);
    rst_n = 1'b1;
    #1;
    check("rst_seq_no_capture", {COUT_reg, S_reg}, 33'd0);
    @(posedge clk);
    #1;
    check("rst_seq_recapture", {COUT_reg, S_reg}, 33'd12);

    prev = 33'd12;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      check("rand_prev_reg", {COUT_reg, S_reg}, prev);
      A   = $urandom;
      B   = $urandom;
      CIN = 1'($urandom_range(1, 0));
      #1;
      ref_sum = {1'b0, A} + {1'b0, B} + {32'h0, CIN};
      check("rand_comb", {COUT, S}, ref_sum);
      @(posedge clk);
      #1;
      check("rand_reg", {COUT_reg, S_reg}, ref_sum);
      prev = ref_sum;
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied,
             miscompares);
    $finish;
  end

endmodule

// File: doc/p4_adder.md
Name: p4_adder

Overview:
- Parameterised Pentium-4-style sparse-tree adder.
- Computes S = A + B + CIN combinationally, with carry-out.
- Also provides a registered copy of the result, so it drops into a clocked datapath behind a single-clock, async-active-low-reset boundary.
- Sits in the ALU/datapath as the main integer adder.

Parameters:
- DWIDTH, 32, operand/sum width; must be a power of two and ≥ 8.
- CARRY_STEP, 4, bit spacing of the carries produced by the sparse tree; must divide DWIDTH and be a power of two.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- A  input  DWIDTH  operand A, unsigned/two's complement.
- B  input  DWIDTH  operand B.
- CIN  input  1  carry-in.
- S  output  DWIDTH  combinational sum.
- COUT  output  1  combinational carry-out.
- S_reg  output  DWIDTH  S registered on rising clk.
- COUT_reg  output  1  COUT registered on rising clk.

Behaviour:
- Combinational path
  - S = (A + B + CIN) mod 2^DWIDTH.
  - COUT = bit DWIDTH of the full DWIDTH+1-bit sum.
  - No clock dependency; settles within one half-period at target frequency.
- Carry generator
  - Per-bit g = a&b and p = a^b; CIN is merged into bit 0 generate: g0 = a0&b0 | (a0^b0)&CIN.
  - Radix-2 prefix tree (Brent-Kung style) up to CARRY_STEP granularity, then Sklansky-style fan-out.
  - Produces carries C[k·CARRY_STEP] for k = 1..DWIDTH/CARRY_STEP.
  - The last carry is COUT.
- Sum generator
  - DWIDTH/CARRY_STEP carry-select blocks of CARRY_STEP bits.
  - Each block has two RCAs (cin = 0 and cin = 1) and a mux selected by the incoming sparse carry.
  - Block 0 selects on CIN.
- Registered path
  - On rising clk: S_reg ← S, COUT_reg ← COUT.
  - Latency is 1 cycle from operand change to registered output.
- Reset
  - rst_n low immediately forces S_reg = 0 and COUT_reg = 0, regardless of clk.
  - Combinational S/COUT keep tracking inputs during reset.
  - First capture occurs at the first rising clk after rst_n deasserts.
- Boundaries
  - Overflow wraps mod 2^DWIDTH, with COUT = 1.
  - No overflow flag; signed overflow is the caller's job.
  - X/Z on inputs propagates; no sanitising.

Decomposition:
- Package p4_pkg
  - DWIDTH default and CARRY_STEP default.
  - Function computing the number of tree levels, clog2(DWIDTH).
  - Function defining, per level and column, whether a G or PG cell is present.
- Natural sub-module: p4_carry_gen, the sparse tree producing the carry vector.
- Carry-select sum blocks are generate loops inside p4_adder.

Test Plan:
- A=0x0000_0000, B=0x0000_0000, CIN=0 -> S=0x0000_0000, COUT=0; after one clk, S_reg=0, COUT_reg=0.
- A=0xFFFF_FFFF, B=0x0000_0000, CIN=1 -> S=0x0000_0000, COUT=1; full carry ripple through every sparse carry.
- A=0x7FFF_FFFF, B=0x0000_0001, CIN=0 -> S=0x8000_0000, COUT=0.
- A=0x1234_5678, B=0x9ABC_DEF0, CIN=1 -> S=0xACF1_3569, COUT=0; then A=0xFFFF_FFFF, B=0xFFFF_FFFF, CIN=1 -> S=0xFFFF_FFFF, COUT=1.
- Reset mid-operation:
  - Drive A=5, B=7 and clock once -> S_reg=12.
  - Assert rst_n=0 between edges -> S_reg=0, COUT_reg=0 immediately, while S=12 stays.
  - Release rst_n, next rising edge -> S_reg=12.
- Random sweep of 10,000 A/B/CIN triples plus carry-boundary patterns (0x0000_000F+1, 0x0000_00FF+1, …) -> S/COUT match the {COUT,S} = A+B+CIN reference; S_reg/COUT_reg equal the previous-cycle S/COUT.
